// File: rtl/decode_execute_core_pkg.sv
// Shared encodings for the decode/execute slice: opcodes, funct codes,
// ALU operation select and branch condition codes.
package decode_execute_core_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_SLT   = 4'b0100,
    ALU_FUNCT = 4'b1111
  } alu_op_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

endpackage

// File: rtl/decode_execute_core_reg_file.sv
// 32x32 register file: two asynchronous read ports, one clocked write port,
// synchronous clear. Register 0 is hardwired to zero.
module decode_execute_core_reg_file (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write shows up next cycle.
  assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs[ra2];

endmodule

// File: rtl/decode_execute_core.sv
// Control decode, register file and ALU of a single-cycle MIPS-subset datapath.
// Everything except the register contents is combinational.
module decode_execute_core
  import decode_execute_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [31:0] write_data,
  output logic        jump,
  output logic [1:0]  branch_c,
  output logic        mem_read,
  output logic        mem_to_reg,
  output logic        mem_write,
  output logic [31:0] alu_result,
  output logic        alu_zero,
  output logic [31:0] mem_write_data,
  output logic [31:0] branch_offset,
  output logic [25:0] jump_index
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;

  logic        reg_dst;
  logic        alu_src;
  logic        reg_write;
  logic        dec_mem_read;
  logic        dec_mem_to_reg;
  logic        dec_mem_write;
  logic [1:0]  dec_branch_c;
  logic        dec_jump;
  logic        sign_ext;
  alu_op_t     alu_op;

  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  dest;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];

  always_comb begin
    reg_dst        = 1'b0;
    alu_src        = 1'b0;
    reg_write      = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_mem_write  = 1'b0;
    dec_branch_c   = BR_NONE;
    dec_jump       = 1'b0;
    sign_ext       = 1'b1;
    alu_op         = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      OP_LW: begin
        alu_src        = 1'b1;
        reg_write      = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      OP_SW: begin
        alu_src       = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_branch_c = BR_EQ;
        alu_op       = ALU_SUB;
      end
      OP_BNE: begin
        dec_branch_c = BR_NE;
        alu_op       = ALU_SUB;
      end
      OP_J: dec_jump = 1'b1;
      OP_ADDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_SLTI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_SLT;
      end
      OP_ANDI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_AND;
        sign_ext  = 1'b0;
      end
      OP_ORI: begin
        alu_src   = 1'b1;
        reg_write = 1'b1;
        alu_op    = ALU_OR;
        sign_ext  = 1'b0;
      end
      default: ;
    endcase
  end

  // Reset gates every strobe, including the internal register write enable.
  assign jump       = dec_jump       & ~reset;
  assign branch_c   = dec_branch_c   & {2{~reset}};
  assign mem_read   = dec_mem_read   & ~reset;
  assign mem_to_reg = dec_mem_to_reg & ~reset;
  assign mem_write  = dec_mem_write  & ~reset;

  assign dest = reg_dst ? rd : rt;

  decode_execute_core_reg_file u_reg_file (
    .clk   (clk),
    .reset (reset),
    .we    (reg_write & ~reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (dest),
    .wd    (write_data),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  assign imm  = sign_ext ? {{16{instruction[15]}}, instruction[15:0]}
                         : {16'd0, instruction[15:0]};
  assign op_a = rs_val;
  assign op_b = alu_src ? imm : rt_val;

  always_comb begin
    alu_result = 32'd0;
    case (alu_op)
      ALU_ADD: alu_result = op_a + op_b;
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_SLT: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
      ALU_FUNCT: begin
        case (funct)
          FN_ADD: alu_result = op_a + op_b;
          FN_SUB: alu_result = op_a - op_b;
          FN_AND: alu_result = op_a & op_b;
          FN_OR:  alu_result = op_a | op_b;
          FN_XOR: alu_result = op_a ^ op_b;
          FN_NOR: alu_result = ~(op_a | op_b);
          FN_SLT: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
          FN_SLL: alu_result = rt_val << shamt;
          FN_SRL: alu_result = rt_val >> shamt;
          default: alu_result = 32'd0;
        endcase
      end
      default: alu_result = 32'd0;
    endcase
  end

  assign alu_zero       = (alu_result == 32'd0);
  assign mem_write_data = rt_val;
  assign branch_offset  = {{14{instruction[15]}}, instruction[15:0], 2'b00};
  assign jump_index     = instruction[25:0];

endmodule

// File: tb/tb_decode_execute_core.sv
// Directed self-checking bench for decode_execute_core with hand-computed
// expected values and immediate assertions at each check point.
module tb_decode_execute_core;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] write_data;
  logic        jump;
  logic [1:0]  branch_c;
  logic        mem_read;
  logic        mem_to_reg;
  logic        mem_write;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] mem_write_data;
  logic [31:0] branch_offset;
  logic [25:0] jump_index;

  int total = 0;
  int bad   = 0;

  decode_execute_core dut (
    .clk            (clk),
    .reset          (reset),
    .instruction    (instruction),
    .write_data     (write_data),
    .jump           (jump),
    .branch_c       (branch_c),
    .mem_read       (mem_read),
    .mem_to_reg     (mem_to_reg),
    .mem_write      (mem_write),
    .alu_result     (alu_result),
    .alu_zero       (alu_zero),
    .mem_write_data (mem_write_data),
    .branch_offset  (branch_offset),
    .jump_index     (jump_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sh, fn};
  endfunction

  // Inputs change 1 time unit after a rising edge; checks happen 2 units later.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] wd);
    instruction = instr;
    write_data  = wd;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    reset       = 1'b1;
    instruction = '0;
    write_data  = '0;

    // Controls gated while reset is high
    applyStimulus(itype(6'h2B, 5'd0, 5'd2, 16'd8), 32'h0);
    checkOutput("rst_sw_mem_write", {31'd0, mem_write}, 32'd0);
    applyStimulus(itype(6'h04, 5'd0, 5'd0, 16'd1), 32'h0);
    checkOutput("rst_beq_branch_c", {30'd0, branch_c}, 32'd0);
    applyStimulus({6'b000010, 26'h0000010}, 32'h0);
    checkOutput("rst_j_jump", {31'd0, jump}, 32'd0);
    tick();
    reset = 1'b0;

    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h25), 32'h0);
    checkOutput("rst_regs_zero", alu_result, 32'd0);

    // addi $1,$0,5 then add $2,$1,$1
    applyStimulus(32'h20010005, 32'd5);
    checkOutput("addi_result", alu_result, 32'd5);
    tick();
    applyStimulus(rtype(5'd1, 5'd1, 5'd2, 5'd0, 6'h20), 32'd10);
    checkOutput("add_result", alu_result, 32'd10);
    tick();
    applyStimulus(rtype(5'd2, 5'd0, 5'd0, 5'd0, 6'h20), 32'h1234);
    checkOutput("add_rd2_written", alu_result, 32'd10);
    tick();
    applyStimulus(rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h25), 32'h0);
    checkOutput("r0_stays_zero", alu_result, 32'd0);

    // Same-cycle write returns old value, new value after the edge
    applyStimulus(itype(6'h08, 5'd0, 5'd3, 16'd7), 32'd7);
    tick();
    applyStimulus(itype(6'h08, 5'd1, 5'd1, 16'd0), 32'd7);
    checkOutput("old_value_before_edge", alu_result, 32'd5);
    tick();
    checkOutput("new_value_after_edge", alu_result, 32'd7);

    // beq $1,$3 with imm 0xFFFF
    applyStimulus(itype(6'h04, 5'd1, 5'd3, 16'hFFFF), 32'hDEAD);
    checkOutput("beq_branch_c", {30'd0, branch_c}, 32'd1);
    checkOutput("beq_zero", {31'd0, alu_zero}, 32'd1);
    checkOutput("beq_offset", branch_offset, 32'hFFFFFFFC);
    tick();
    applyStimulus(itype(6'h05, 5'd1, 5'd3, 16'h0004), 32'h0);
    checkOutput("bne_branch_c", {30'd0, branch_c}, 32'd2);
    checkOutput("bne_zero_no_write", {31'd0, alu_zero}, 32'd1);
    checkOutput("bne_offset", branch_offset, 32'h00000010);

    // $1 = 0x8000ABCD, then signed slti and zero-extended andi/ori
    applyStimulus(itype(6'h08, 5'd0, 5'd1, 16'd0), 32'h8000ABCD);
    tick();
    applyStimulus(itype(6'h0A, 5'd1, 5'd4, 16'hFFFF), 32'h0);
    checkOutput("slti_signed", alu_result, 32'd1);
    applyStimulus(itype(6'h0A, 5'd3, 5'd4, 16'hFFFF), 32'h0);
    checkOutput("slti_false", alu_result, 32'd0);
    applyStimulus(itype(6'h0C, 5'd1, 5'd4, 16'hFFFF), 32'h0);
    checkOutput("andi_zext", alu_result, 32'h0000ABCD);
    applyStimulus(itype(6'h0D, 5'd0, 5'd4, 16'h8001), 32'h0);
    checkOutput("ori_zext", alu_result, 32'h00008001);

    // sw $2,8($0): store strobe, address, data, no write to $2
    applyStimulus(itype(6'h2B, 5'd0, 5'd2, 16'd8), 32'h5555);
    checkOutput("sw_mem_write", {31'd0, mem_write}, 32'd1);
    checkOutput("sw_addr", alu_result, 32'd8);
    checkOutput("sw_data", mem_write_data, 32'd10);
    checkOutput("sw_mem_read", {31'd0, mem_read}, 32'd0);
    tick();
    applyStimulus(rtype(5'd2, 5'd0, 5'd0, 5'd0, 6'h20), 32'h0);
    checkOutput("sw_no_reg_write", alu_result, 32'd10);

    // lw $5,4($0)
    applyStimulus(itype(6'h23, 5'd0, 5'd5, 16'd4), 32'h0);
    checkOutput("lw_mem_read", {31'd0, mem_read}, 32'd1);
    checkOutput("lw_mem_to_reg", {31'd0, mem_to_reg}, 32'd1);
    checkOutput("lw_addr", alu_result, 32'd4);

    // Undefined opcode: no strobes, no register write
    applyStimulus(itype(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h0BAD);
    checkOutput("undef_ctrl", {26'd0, jump, branch_c, mem_read, mem_to_reg, mem_write}, 32'd0);
    tick();
    applyStimulus(rtype(5'd2, 5'd0, 5'd0, 5'd0, 6'h20), 32'h0);
    checkOutput("undef_no_write", alu_result, 32'd10);

    // j 0x0000010
    applyStimulus({6'b000010, 26'h0000010}, 32'h0);
    checkOutput("j_jump", {31'd0, jump}, 32'd1);
    checkOutput("j_index", {6'd0, jump_index}, 32'h00000010);
    checkOutput("j_other_ctrl", {27'd0, branch_c, mem_read, mem_write}, 32'd0);

    // R-type funct coverage, rd=0 so nothing is written ($1=0x8000ABCD, $2=10)
    applyStimulus(rtype(5'd2, 5'd1, 5'd0, 5'd0, 6'h22), 32'h0);
    checkOutput("r_sub", alu_result, 32'h7FFF543D);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h24), 32'h0);
    checkOutput("r_and", alu_result, 32'h00000008);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h26), 32'h0);
    checkOutput("r_xor", alu_result, 32'h8000ABC7);
    applyStimulus(rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h27), 32'h0);
    checkOutput("r_nor", alu_result, 32'hFFFFFFFF);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h2A), 32'h0);
    checkOutput("r_slt_signed", alu_result, 32'd1);
    applyStimulus(rtype(5'd2, 5'd1, 5'd0, 5'd0, 6'h2A), 32'h0);
    checkOutput("r_slt_false", alu_result, 32'd0);
    applyStimulus(rtype(5'd0, 5'd2, 5'd0, 5'd4, 6'h00), 32'h0);
    checkOutput("r_sll", alu_result, 32'h000000A0);
    applyStimulus(rtype(5'd0, 5'd1, 5'd0, 5'd4, 6'h02), 32'h0);
    checkOutput("r_srl", alu_result, 32'h08000ABC);
    applyStimulus(rtype(5'd1, 5'd2, 5'd0, 5'd0, 6'h3F), 32'h0);
    checkOutput("r_bad_funct", alu_result, 32'd0);
    checkOutput("r_bad_funct_zero", {31'd0, alu_zero}, 32'd1);

    // Reset clears registers and wins over a simultaneous write
    reset = 1'b1;
    applyStimulus(itype(6'h08, 5'd0, 5'd2, 16'd0), 32'h77);
    tick();
    reset = 1'b0;
    applyStimulus(rtype(5'd2, 5'd0, 5'd0, 5'd0, 6'h25), 32'h0);
    checkOutput("rst_clears_r2", alu_result, 32'd0);
    applyStimulus(rtype(5'd1, 5'd0, 5'd0, 5'd0, 6'h25), 32'h0);
    checkOutput("rst_clears_r1", alu_result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_execute_core.md
Name: decode_execute_core

Overview:
- Combinational control decode, register file and ALU of a single-cycle, non-pipelined MIPS-subset datapath.
- Takes the fetched instruction and the write-back value from the memory stage.
- Produces control strobes for fetch and memory, the ALU result and zero flag, the store data, and the branch/jump target fields.
- Only state is the 32x32 register file.

Parameters:
- none (data width 32, 32 registers, both fixed)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- instruction  in  32  current instruction
- write_data  in  32  write-back value written to destination register
- jump  out  1  unconditional jump taken
- branch_c  out  2  00 none, 01 beq (taken if alu_zero), 10 bne (taken if !alu_zero)
- mem_read  out  1  load strobe
- mem_to_reg  out  1  write-back selects memory data
- mem_write  out  1  store strobe
- alu_result  out  32  ALU output; also the memory address
- alu_zero  out  1  alu_result == 0
- mem_write_data  out  32  rt register value (store data)
- branch_offset  out  32  sign-extended imm[15:0] shifted left 2
- jump_index  out  26  instruction[25:0]

Behaviour:
- Opcode decode (instruction[31:26]); fields are reg_dst/alu_src/reg_write/mem_read/mem_to_reg/mem_write/branch_c/jump/alu_op:
  - 000000 R-type: 1/0/1/0/0/0/00/0/FUNCT
  - 100011 lw: 0/1/1/1/1/0/00/0/ADD
  - 101011 sw: x/1/0/0/0/1/00/0/ADD
  - 000100 beq: branch_c=01, ALU op SUB, rs vs rt
  - 000101 bne: branch_c=10, ALU op SUB, rs vs rt
  - 000010 j: jump=1, all others 0
  - 001000 addi: ADD
  - 001010 slti: SLT
  - 001100 andi: AND
  - 001101 ori: OR
  - addi/slti/andi/ori all have alu_src=1, reg_write=1, reg_dst=0
  - Undefined opcode: every control 0 (no write, no memory access).
- alu_op encoding (4 bits):
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT, 1111 FUNCT.
- FUNCT mode decodes instruction[5:0]:
  - 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt: signed
  - 000000 sll, 000010 srl: rt shifted by shamt instruction[10:6], logical
  - Other funct values: alu_result = 0.
- Immediate: sign-extended for addi, slti, lw, sw, beq, bne; zero-extended for andi, ori.
- ALU operand A = rs value (instruction[25:21]); operand B = alu_src ? immediate : rt value (instruction[20:16]).
- Arithmetic wraps modulo 2^32; no overflow trap.
- While reset = 1, all control outputs are forced to 0, combinationally gated.
- Register file:
  - 32 x 32 bits; two asynchronous read ports (rs, rt).
  - One write port on the clk rising edge when reg_write = 1 and reset = 0.
  - Destination = reg_dst ? rd (instruction[15:11]) : rt.
  - Register 0 reads 0 always; writes to it are discarded.
  - A read of a register written in the same cycle returns the old value; the new value is visible from the next cycle.
  - reset = 1 at a clk edge clears all 32 registers; reset has priority over a simultaneous write.
- All outputs other than the register contents are combinational functions of instruction and register state; zero-cycle latency.

Decomposition:
- Shared package holds opcode constants, funct constants, the alu_op enum, and the branch_c encoding.
- One sub-module: reg_file (32x32, 2R/1W, synchronous clear).
- Control decode and ALU stay inline.

Test Plan:
- Reset: reset=1 for one edge; all registers read 0; jump/mem_write/branch_c = 0 while reset high.
- addi $1,$0,5 (0x20010005), write_data=5, one edge; then add $2,$1,$1 → alu_result=10, reg_write path selects rd=2.
- sub giving 0: $1=$3=7, beq $1,$3 → branch_c=01, alu_zero=1; branch_offset for imm 0xFFFF = 0xFFFFFFFC.
- slti $4,$1,-1 with $1=0x80000000 → alu_result=1 (signed compare); andi imm 0xFFFF zero-extends → $1 & 0x0000FFFF.
- sw $2,8($0) → mem_write=1, alu_result=8, mem_write_data=$2, no register write; a write_data to $0 leaves $0 = 0.
- Undefined opcode 0x3F → all controls 0, no register changes; j 0x0000010 → jump=1, jump_index=0x0000010.
